// File: rtl/xnor_bist.sv
// Exhaustive 3-input BIST: steps {a,b,c} through vectors 0..7 and holds each one for SETTLE+1 cycles.
// The response f_in is compared against EXPECT on the last cycle of each vector.
module xnor_bist #(
    parameter int unsigned SETTLE = 4,
    parameter logic [7:0]  EXPECT = 8'h96
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       f_in,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] fail_vec
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

    state_t     state;
    logic [2:0] vec_idx;
    logic [3:0] cnt;
    logic       mismatch;

    assign mismatch = (f_in != EXPECT[vec_idx]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            vec_idx   <= '0;
            cnt       <= '0;
            a         <= 1'b0;
            b         <= 1'b0;
            c         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_SETTLE;
                        vec_idx   <= '0;
                        cnt       <= '0;
                        {a, b, c} <= 3'd0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        err_count <= '0;
                        fail_vec  <= '0;
                    end
                end
                S_SETTLE: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == CNT_LAST) begin
                        state <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    if (mismatch) begin
                        err_count         <= err_count + 4'd1;
                        fail_vec[vec_idx] <= 1'b1;
                    end
                    if (vec_idx == 3'd7) begin
                        // pass is registered here, so it must include this last comparison
                        state     <= S_DONE;
                        {a, b, c} <= 3'd0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        pass      <= (err_count == 4'd0) && !mismatch;
                    end else begin
                        state     <= S_SETTLE;
                        vec_idx   <= vec_idx + 3'd1;
                        cnt       <= '0;
                        {a, b, c} <= vec_idx + 3'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xnor_bist.sv
// Bench for xnor_bist: default and SETTLE=1 instances driven by a per-vector response table,
// checked every cycle against a cycle-count model plus hand-computed run results.
module tb_xnor_bist;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] tt;
    logic [7:0] exp_tt = 8'h96;

    logic [1:0] a_o, b_o, c_o, busy_o, done_o, pass_o, f_o;
    logic [3:0] err_o [2];
    logic [7:0] fail_o [2];

    int checks = 0;
    int errors = 0;

    // model state per instance
    int unsigned m_s [2] = '{4, 1};
    bit          m_run [2];
    bit          m_done [2];
    int unsigned m_k [2];
    logic [7:0]  m_fail [2];

    always #5 clk = ~clk;

    assign f_o[0] = tt[{a_o[0], b_o[0], c_o[0]}];
    assign f_o[1] = tt[{a_o[1], b_o[1], c_o[1]}];

    xnor_bist dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .f_in(f_o[0]),
        .a(a_o[0]), .b(b_o[0]), .c(c_o[0]), .busy(busy_o[0]), .done(done_o[0]),
        .pass(pass_o[0]), .err_count(err_o[0]), .fail_vec(fail_o[0])
    );

    xnor_bist #(.SETTLE(1), .EXPECT(8'h96)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .f_in(f_o[1]),
        .a(a_o[1]), .b(b_o[1]), .c(c_o[1]), .busy(busy_o[1]), .done(done_o[1]),
        .pass(pass_o[1]), .err_count(err_o[1]), .fail_vec(fail_o[1])
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare then advance the model; inputs are stable from posedge+2 to the next posedge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int unsigned hold;
            hold = m_s[i] + 1;
            if (!rst_n) begin
                m_run[i]  = 0;
                m_done[i] = 0;
                m_k[i]    = 0;
                m_fail[i] = '0;
            end
            check($sformatf("busy%0d", i), int'(busy_o[i]), int'(m_run[i]));
            check($sformatf("done%0d", i), int'(done_o[i]), int'(m_done[i]));
            check($sformatf("pass%0d", i), int'(pass_o[i]), int'(m_done[i] && m_fail[i] == 8'h00));
            check($sformatf("abc%0d", i), int'({a_o[i], b_o[i], c_o[i]}),
                  m_run[i] ? int'(m_k[i] / hold) : 0);
            check($sformatf("err%0d", i), int'(err_o[i]), $countones(m_fail[i]));
            check($sformatf("fail_vec%0d", i), int'(fail_o[i]), int'(m_fail[i]));
            if (rst_n) begin
                if (m_run[i]) begin
                    if (m_k[i] % hold == hold - 1) begin
                        int unsigned v;
                        v = m_k[i] / hold;
                        if (f_o[i] != exp_tt[v]) m_fail[i][v] = 1'b1;
                    end
                    m_k[i]++;
                    if (m_k[i] == 8 * hold) begin
                        m_run[i]  = 0;
                        m_done[i] = 1;
                    end
                end else if (start) begin
                    m_run[i]  = 1;
                    m_done[i] = 0;
                    m_k[i]    = 0;
                    m_fail[i] = '0;
                end
            end
        end
    end

    task automatic wait_done0(output int cycles);
        cycles = 0;
        while (!done_o[0] && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic do_run(input logic [7:0] t, input int exp_err, input int exp_fail);
        int cycles, d1;
        tt = t;
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        cycles = 0;
        d1 = -1;
        while (!done_o[0] && cycles < 200) begin
            @(posedge clk); #1;
            cycles++;
            if (done_o[1] && d1 < 0) d1 = cycles;
        end
        check("done_latency", cycles, 40);
        check("done_latency_s1", d1, 16);
        check("run_err", int'(err_o[0]), exp_err);
        check("run_fail_vec", int'(fail_o[0]), exp_fail);
        check("run_pass", int'(pass_o[0]), int'(exp_err == 0));
        check("run_err_s1", int'(err_o[1]), exp_err);
        check("run_pass_s1", int'(pass_o[1]), int'(exp_err == 0));
    endtask

    initial begin
        int cyc;
        logic [7:0] r;
        rst_n = 1'b0;
        start = 1'b0;
        tt    = 8'h96;
        #1;
        check("reset_busy", int'(busy_o[0]), 0);
        check("reset_err", int'(err_o[0]), 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        check("idle_no_run", int'(busy_o[0] | done_o[0]), 0);

        do_run(8'h96, 0, 8'h00);
        do_run(8'h00, 4, 8'h96);
        do_run(8'h69, 8, 8'hFF);
        for (int n = 0; n < 6; n++) begin
            r = 8'($urandom);
            do_run(r, $countones(r ^ 8'h96), int'(r ^ 8'h96));
        end

        // start held high across a whole run, then restart from DONE
        tt = 8'h00;
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #1;
        wait_done0(cyc);
        check("held_latency", cyc, 40);
        check("held_err", int'(err_o[0]), 4);
        @(posedge clk); #1;
        check("restart_err", int'(err_o[0]), 0);
        check("restart_busy", int'(busy_o[0]), 1);
        check("restart_a", int'(a_o[0]), 0);
        #1 start = 1'b0;
        wait_done0(cyc);
        check("held_second_done", int'(done_o[0]), 1);

        // reset in the middle of vector 5
        tt = 8'h96;
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        cyc = 0;
        while ({a_o[0], b_o[0], c_o[0]} != 3'd5 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("reach_vec5", int'({a_o[0], b_o[0], c_o[0]}), 5);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        check("async_abc", int'({a_o[0], b_o[0], c_o[0]}), 0);
        check("async_busy", int'(busy_o[0]), 0);
        check("async_flags", int'({done_o[0], pass_o[0]}), 0);
        check("async_results", int'({err_o[0], fail_o[0]}), 0);
        @(posedge clk); #2 rst_n = 1'b1;
        do_run(8'h96, 0, 8'h00);

        // random start pulses, response tables and occasional resets
        for (int n = 0; n < 1500; n++) begin
            @(posedge clk); #2;
            start = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 63) == 0) tt = 8'($urandom);
            rst_n = ($urandom_range(0, 499) != 0);
        end
        @(posedge clk); #2 rst_n = 1'b1; start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xnor_bist.md
XNOR_BIST -- requirements
Module: xnor_bist

Interface
REQ-001 Parameter SETTLE, default 4: clock cycles each vector is held before its response is sampled; legal range 1..15.
REQ-002 Parameter EXPECT, default 8'h96: expected truth table; bit i is the expected f for {a,b,c}=i. The default is the cascaded two-input XNOR, f = a^b^c.
REQ-003 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request a test run; sampled only in IDLE and DONE.
REQ-006 f_in  input  1  response from the unit under test; same clock domain, no synchroniser.
REQ-007 a  output  1  stimulus bit 2 (MSB of the vector index).
REQ-008 b  output  1  stimulus bit 1.
REQ-009 c  output  1  stimulus bit 0.
REQ-010 busy  output  1  high in SETTLE and SAMPLE.
REQ-011 done  output  1  high while in DONE.
REQ-012 pass  output  1  valid when done=1; high when err_count=0.
REQ-013 err_count  output  4  number of mismatching vectors in the last run (0..8).
REQ-014 fail_vec  output  8  bit i set when vector i mismatched.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, SETTLE, SAMPLE, DONE.
REQ-016 IDLE with start=1: at the next edge the FSM SHALL go to SETTLE with vec_idx=0 and cnt=0, and SHALL clear err_count and fail_vec.
REQ-017 DONE with start=1: the FSM SHALL behave exactly as REQ-016 (restart); DONE with start=0 SHALL hold all results.
REQ-018 SETTLE: cnt SHALL increment by 1 each cycle; when cnt=SETTLE-1, the next state SHALL be SAMPLE. SETTLE therefore lasts exactly SETTLE cycles.
REQ-019 SAMPLE (one cycle): f_in SHALL be compared with EXPECT[vec_idx].
  - On mismatch: err_count increments by 1 and fail_vec[vec_idx] is set.
  - If vec_idx=7: next state DONE.
  - Otherwise: vec_idx increments by 1, cnt clears to 0, next state SETTLE.
REQ-020 {a,b,c} SHALL be registered and equal vec_idx in SETTLE and SAMPLE. They SHALL be 0 in IDLE and DONE.
REQ-021 Each vector SHALL be held for SETTLE+1 cycles. done SHALL rise exactly 8*(SETTLE+1) cycles after the edge that accepted start (40 cycles at the default SETTLE).
REQ-022 start SHALL be ignored in SETTLE and SAMPLE; a run SHALL never be restarted or extended while busy.
REQ-023 err_count SHALL saturate naturally at 8 and never wrap; 4 bits are sufficient.
REQ-024 pass SHALL equal done AND (err_count==0); pass SHALL be 0 outside DONE.
REQ-025 busy and done SHALL be mutually exclusive; both SHALL be 0 in IDLE.

Reset
REQ-026 When rst_n=0, the block SHALL immediately, without waiting for clk, force: state=IDLE, vec_idx=0, cnt=0, a=b=c=0, busy=0, done=0, pass=0, err_count=0, fail_vec=8'h00.
REQ-027 Reset asserted mid-run SHALL abort the run with no partial results retained. The first start after rst_n deasserts SHALL begin at vector 0.
REQ-028 No run SHALL begin until start=1 is sampled after reset release.

Verification
REQ-029 Good DUT: f_in=a^b^c, default parameters, one-cycle start pulse -> done=1 after 40 cycles, pass=1, err_count=0, fail_vec=8'h00.
REQ-030 Stuck-at-0 DUT: f_in=0 -> err_count=4, fail_vec=8'h96, pass=0.
REQ-031 Inverted DUT: f_in=~(a^b^c) -> err_count=8, fail_vec=8'hFF, pass=0.
REQ-032 Hold start=1 for the entire run -> exactly one run occurs. From DONE, the held start restarts: results clear and a is 0 on the next cycle.
REQ-033 Pull rst_n low at vector 5, mid-SETTLE -> all outputs 0 asynchronously. After release plus start, a good DUT gives pass=1 after 40 cycles.
REQ-034 SETTLE=1 -> each vector is held for 2 cycles and done is reached after 16 cycles; with a good DUT, pass=1.
